float_to_int: RTL and testbench
===============================

FLOAT_TO_INT -- requirements
Module: float_to_int

Interface
REQ-001 The block SHALL have parameter float_size, default 32, meaning the total width of the floating-point input; legal values are 16, 32 and 64.
REQ-002 The block SHALL have parameter int_size, default 16, meaning the width of the two's-complement signed output; legal values are 4 to 64.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: float_in is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept an input.
REQ-007 The block SHALL have port float_in, input, float_size bits, laid out as {sign, exponent, mantissa}.
REQ-008 The block SHALL have port out_valid, output, 1 bit: int_out and the flags are valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-010 The block SHALL have port int_out, output, int_size bits: the signed integer result.
REQ-011 The block SHALL have port overflow, output, 1 bit: the result was saturated.
REQ-012 The block SHALL have port invalid, output, 1 bit: the input was NaN.

Function
REQ-013 Exponent width, mantissa width and bias SHALL come from the shared reflet_float.vh helpers; e = exponent field - bias.
REQ-014 The FSM SHALL have states IDLE, ALIGN, FINISH and DONE; in_ready = (state == IDLE); out_valid = (state == DONE).
REQ-015 An input SHALL be accepted on an edge where in_valid and in_ready are both high; float_in is registered on that edge; in_valid outside IDLE is ignored.
REQ-016 On acceptance, a W = mantissa_size + int_size bit accumulator SHALL load {zeros, 1, mantissa}, and a shift counter SHALL load e.
REQ-017 On acceptance, next state SHALL be ALIGN if 0 < e < int_size-1 and the exponent field is not all-ones; otherwise next state is FINISH.
REQ-018 ALIGN SHALL shift the accumulator left 1 bit per cycle and decrement the counter; the state moves to FINISH on the edge that performs the e-th shift.
REQ-019 In FINISH, magnitude SHALL be the integer part accum[W-1:mantissa_size], negated when sign=1; results and flags are registered and the state moves to DONE.
REQ-020 Latency SHALL be exactly 1+e edges from the accept edge to out_valid high for shifted cases, and exactly 1 edge otherwise.
REQ-021 DONE SHALL hold int_out and the flags stable until out_ready is high; the state then moves to IDLE, so there is no accept in the same cycle.
REQ-022 Exponent field 0 (zero or subnormal) and e < 0 SHALL produce 0 with both flags low, except as given by REQ-033.
REQ-023 A NaN input (exponent all-ones, mantissa != 0) SHALL produce int_out 0 with invalid=1 and overflow=0.
REQ-024 Infinity or e >= int_size-1 SHALL saturate: sign 0 gives 2^(int_size-1)-1, sign 1 gives -2^(int_size-1), with overflow=1.
REQ-025 An input of exactly -2^(int_size-1) (sign 1, e = int_size-1, mantissa 0) SHALL produce the minimum value with overflow=0.
REQ-026 Flags SHALL be low whenever out_valid is low.

Reset
REQ-027 Reset SHALL be asserted asynchronously and can occur in any state, including mid-ALIGN.
REQ-028 While reset is high, the state SHALL be IDLE, int_out 0, out_valid 0, overflow 0, invalid 0, and the accumulator and counter 0.
REQ-029 in_ready SHALL be 1 while reset is high, and an in-flight conversion is discarded.
REQ-030 The first accept after reset release SHALL be possible on the first rising edge with in_valid high.

Configuration
REQ-031 Macro REFLET_FLOAT_ROUND_EN SHALL select the rounding mode.
REQ-032 When REFLET_FLOAT_ROUND_EN is undefined, the conversion SHALL truncate toward zero on the magnitude.
REQ-033 When REFLET_FLOAT_ROUND_EN is defined, FINISH SHALL round to nearest, ties to even.
 - round bit = accum[mantissa_size-1]; sticky = OR of the lower bits.
 - e = -1: round bit is the implicit 1 and sticky = |mantissa.
 - e < -1: result 0.
REQ-034 A rounded-up magnitude equal to 2^(int_size-1) SHALL saturate with overflow=1 when positive, and give the minimum value with overflow=0 when negative.
REQ-035 Latency SHALL be identical in both builds.

Verification (float_size=32, int_size=16)
REQ-036 0x3F800000 (1.0) -> int_out 0x0001, flags 0, out_valid 1 edge after accept.
REQ-037 0xC47A0000 (-1000.0) -> 0xFC18, out_valid 10 edges after accept; 0xC7000000 -> 0x8000, overflow 0.
REQ-038 0x471C4000 (40000.0) -> 0x7FFF, overflow 1; 0x7F800000 -> 0x7FFF, overflow 1; 0x7FC00000 -> 0x0000, invalid 1.
REQ-039 Rounding inputs -> truncate build / round build:
 - 0x40200000 (2.5) -> 2 / 2.
 - 0x40600000 (3.5) -> 3 / 4.
 - 0x3F400000 (0.75) -> 0 / 1.
 - 0xBFC00000 (-1.5) -> 0xFFFF / 0xFFFE.
REQ-040 Backpressure: out_ready low for 5 cycles in DONE -> int_out stable and in_ready 0; out_ready high -> IDLE next edge.
REQ-041 Reset pulse during ALIGN of 0x46FFFE00 -> out_valid 0 and in_ready 1 immediately; a following 1.0 input gives 0x0001.

Source files
------------

// File: rtl/float_to_int.sv
// float_to_int: IEEE-754 (binary16/32/64) to signed integer converter.
// Sequential align: one left shift of the significand per cycle, then a
// finishing cycle that applies sign, saturation and optional rounding.
// Build option: define REFLET_FLOAT_ROUND_EN for round-to-nearest-even;
// left undefined, the magnitude is truncated toward zero.
module float_to_int #(
    parameter int float_size = 32,
    parameter int int_size   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [float_size-1:0] float_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [int_size-1:0]   int_out,
    output logic                  overflow,
    output logic                  invalid
);

    // Field geometry, matching the reflet_float helpers.
    localparam int EXP_SIZE = (float_size == 16) ? 5 : (float_size == 64) ? 11 : 8;
    localparam int MAN_SIZE = float_size - EXP_SIZE - 1;
    localparam int BIAS     = (1 << (EXP_SIZE - 1)) - 1;
    localparam int W        = MAN_SIZE + int_size;
    localparam int CNT_SIZE = EXP_SIZE + 2;

    localparam logic [int_size-1:0] INT_MAX  = {1'b0, {(int_size-1){1'b1}}};
    localparam logic [int_size-1:0] INT_MIN  = {1'b1, {(int_size-1){1'b0}}};
    localparam logic [int_size:0]   MAG_HALF = {2'b01, {(int_size-1){1'b0}}};
    localparam logic [int_size:0]   MAG_ONE  = {{int_size{1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, ALIGN, FINISH, DONE} state_t;

    state_t                       state_q;
    logic [float_size-1:0]        float_q;
    logic [W-1:0]                 accum_q;
    logic signed [CNT_SIZE-1:0]   cnt_q;
    logic [int_size-1:0]          int_out_q;
    logic                         overflow_q;
    logic                         invalid_q;

    // Decode of the incoming word, used only on the accept edge.
    logic [EXP_SIZE-1:0] in_exp;
    logic [MAN_SIZE-1:0] in_man;
    int                  in_e;
    logic                go_align;

    assign in_exp   = float_in[float_size-2 -: EXP_SIZE];
    assign in_man   = float_in[MAN_SIZE-1:0];
    assign in_e     = int'(in_exp) - BIAS;
    assign go_align = (in_e > 0) && (in_e < int_size - 1) && (in_exp != '1);

    // Decode of the held word, used in FINISH.
    logic                f_sign;
    logic [EXP_SIZE-1:0] f_exp;
    logic [MAN_SIZE-1:0] f_man;
    int                  f_e;
    logic [int_size-1:0] int_part;

    assign f_sign   = float_q[float_size-1];
    assign f_exp    = float_q[float_size-2 -: EXP_SIZE];
    assign f_man    = float_q[MAN_SIZE-1:0];
    assign f_e      = int'(f_exp) - BIAS;
    assign int_part = accum_q[W-1:MAN_SIZE];

    logic [int_size:0]   mag;
    logic [int_size-1:0] res_d;
    logic                overflow_d;
    logic                invalid_d;

`ifdef REFLET_FLOAT_ROUND_EN
    logic round_bit;
    logic sticky;
    assign round_bit = accum_q[MAN_SIZE-1];
    assign sticky    = |accum_q[MAN_SIZE-2:0];
`else
    // Fraction bits only matter to the rounding build.
    logic unused_frac;
    assign unused_frac = ^accum_q[MAN_SIZE-1:0];
`endif

    // Result of the finishing cycle: magnitude, sign, saturation and flags.
    always_comb begin
        // NOTE: every output of this block is given a default first so no latch is inferred.
        mag        = {1'b0, int_part};
        res_d      = '0;
        overflow_d = 1'b0;
        invalid_d  = 1'b0;
`ifdef REFLET_FLOAT_ROUND_EN
        if (f_exp == '0 || f_e < -1) begin
            mag = '0;
        end else if (f_e == -1) begin
            // Value in [0.5, 1): round bit is the hidden one, integer part is 0 (even).
            mag = (|f_man) ? MAG_ONE : '0;
        end else if (round_bit && (sticky || int_part[0])) begin
            mag = mag + MAG_ONE;
        end
`else
        if (f_exp == '0 || f_e < 0) begin
            mag = '0;
        end
`endif
        if (f_exp == '1 && f_man != '0) begin
            invalid_d = 1'b1;
        end else if (f_exp == '1 || f_e > int_size - 1 ||
                     (f_e == int_size - 1 && !(f_sign && f_man == '0))) begin
            overflow_d = 1'b1;
            res_d      = f_sign ? INT_MIN : INT_MAX;
        end else if (f_e == int_size - 1) begin
            // Exactly -2^(int_size-1) is representable.
            res_d = INT_MIN;
        end else if (mag == MAG_HALF) begin
            // Rounded up onto 2^(int_size-1): only the negative side fits.
            res_d      = f_sign ? INT_MIN : INT_MAX;
            overflow_d = ~f_sign;
        end else begin
            res_d = f_sign ? -mag[int_size-1:0] : mag[int_size-1:0];
        end
    end

    // Control FSM plus datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q    <= IDLE;
            float_q    <= '0;
            accum_q    <= '0;
            cnt_q      <= '0;
            int_out_q  <= '0;
            overflow_q <= 1'b0;
            invalid_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        float_q <= float_in;
                        accum_q <= {{(int_size-1){1'b0}}, 1'b1, in_man};
                        cnt_q   <= CNT_SIZE'(in_e);
                        state_q <= go_align ? ALIGN : FINISH;
                    end
                end
                ALIGN: begin
                    accum_q <= accum_q << 1;
                    cnt_q   <= cnt_q - CNT_SIZE'(1);
                    if (cnt_q == CNT_SIZE'(1)) begin
                        state_q <= FINISH;
                    end
                end
                FINISH: begin
                    int_out_q  <= res_d;
                    overflow_q <= overflow_d;
                    invalid_q  <= invalid_d;
                    state_q    <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        int_out_q  <= '0;
                        overflow_q <= 1'b0;
                        invalid_q  <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign int_out   = int_out_q;
    assign overflow  = overflow_q;
    assign invalid   = invalid_q;

endmodule

// File: tb/tb_float_to_int.sv
// Self-checking bench for float_to_int (float_size=32, int_size=16).
// A real-arithmetic reference model predicts every result; a negedge
// monitor compares the DUT against it each cycle, and directed cases with
// literal expectations pin both the model and the DUT.
module tb_float_to_int;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] float_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] int_out;
    logic        overflow;
    logic        invalid;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

`ifdef REFLET_FLOAT_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    float_to_int #(.float_size(32), .int_size(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .float_in (float_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .int_out  (int_out),
        .overflow (overflow),
        .invalid  (invalid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: value as a real number, then floor / nearest-even, then range rules.
    function automatic void model(input logic [31:0] f, output logic [15:0] r,
                                  output logic ov, output logic iv, output int lat);
        logic        s;
        int          ex;
        int          e;
        logic [22:0] m;
        real         mag;
        real         fl;
        longint      k;
`ifdef REFLET_FLOAT_ROUND_EN
        real         fr;
`endif
        s  = f[31];
        ex = int'(f[30:23]);
        m  = f[22:0];
        e  = ex - 127;
        r  = 16'h0000;
        ov = 1'b0;
        iv = 1'b0;
        lat = (ex != 255 && e > 0 && e < 15) ? 1 + e : 1;
        if (ex == 255 && m != 0) begin
            iv = 1'b1;
        end else if (ex == 255 || e > 15 || (e == 15 && !(s && m == 0))) begin
            ov = 1'b1;
            r  = s ? 16'h8000 : 16'h7FFF;
        end else if (e == 15) begin
            r = 16'h8000;
        end else if (ex != 0) begin
            mag = (1.0 + real'(m) / 8388608.0) * (2.0 ** e);
            fl  = $floor(mag);
            k   = longint'(fl);
`ifdef REFLET_FLOAT_ROUND_EN
            fr = mag - fl;
            if (fr > 0.5 || (fr == 0.5 && k[0])) k++;
`endif
            if (k >= 32768) begin
                if (s) r = 16'h8000;
                else begin
                    r  = 16'h7FFF;
                    ov = 1'b1;
                end
            end else begin
                r = s ? 16'(-k) : 16'(k);
            end
        end
    endfunction

    // Monitor: one comparison pass per cycle against the model's prediction.
    logic        pend = 1'b0;
    int          acc_cyc = 0;
    int          exp_lat = 1;
    logic [15:0] exp_r = '0;
    logic        exp_ov = 1'b0;
    logic        exp_iv = 1'b0;
    logic        want_v;

    always @(negedge clk) begin
        if (reset) begin
            check("rst_in_ready", in_ready, 1);
            check("rst_out_valid", out_valid, 0);
            check("rst_int_out", int_out, 0);
            check("rst_flags", {overflow, invalid}, 0);
            pend = 1'b0;
        end else begin
            want_v = pend && (cyc >= acc_cyc + exp_lat);
            check("mon_out_valid", out_valid, want_v);
            check("mon_in_ready", in_ready, !pend);
            if (want_v) begin
                check("mon_int_out", int_out, exp_r);
                check("mon_overflow", overflow, exp_ov);
                check("mon_invalid", invalid, exp_iv);
            end else begin
                check("mon_flags_idle", {overflow, invalid}, 0);
            end
            if (want_v && out_ready) begin
                pend = 1'b0;
            end else if (!pend && in_valid) begin
                pend    = 1'b1;
                acc_cyc = cyc + 1;
                model(float_in, exp_r, exp_ov, exp_iv, exp_lat);
            end
        end
    end

    task automatic wait_idle(input string name);
        int n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check({name, "_idle_timeout"}, 0, 1);
    endtask

    // Directed conversion with literal expectations and optional backpressure.
    task automatic convert(input string name, input logic [31:0] f, input logic [15:0] want_r,
                           input logic want_ov, input logic want_iv, input int want_lat,
                           input int hold);
        logic [15:0] mr;
        logic        mo;
        logic        mi;
        int          ml;
        int          lat;
        logic [15:0] held;
        model(f, mr, mo, mi, ml);
        check({name, "_model_val"}, {mr, mo, mi}, {want_r, want_ov, want_iv});
        check({name, "_model_lat"}, ml, want_lat);
        wait_idle(name);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        float_in  = f;
        @(posedge clk); #1;
        float_in = $urandom;  // busy: must be ignored
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid && lat < 64);
        check({name, "_latency"}, lat, want_lat);
        check({name, "_int_out"}, int_out, want_r);
        check({name, "_flags"}, {overflow, invalid}, {want_ov, want_iv});
        held = int_out;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({name, "_hold_val"}, int_out, held);
            check({name, "_hold_busy"}, {out_valid, in_ready}, 2'b10);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check({name, "_release"}, {out_valid, in_ready}, 2'b01);
    endtask

    function automatic logic [31:0] rand_float();
        logic        s;
        logic [7:0]  ex;
        logic [22:0] m;
        int          sel;
        s   = 1'($urandom_range(0, 1));
        sel = $urandom_range(0, 9);
        if (sel == 0)      ex = 8'($urandom_range(0, 126));
        else if (sel == 1) ex = 8'hFF;
        else if (sel == 9) ex = 8'($urandom_range(144, 254));
        else               ex = 8'($urandom_range(126, 143));
        m = 23'($urandom);
        if ($urandom_range(0, 1) == 1) m = m & (23'h7FFFFF << $urandom_range(8, 23));
        return {s, ex, m};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] f;
        bit          accepted;
        int          n;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        float_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        convert("one",      32'h3F800000, 16'h0001, 0, 0, 1,  0);
        convert("neg1000",  32'hC47A0000, 16'hFC18, 0, 0, 10, 5);
        convert("min_exact",32'hC7000000, 16'h8000, 0, 0, 1,  0);
        convert("p40000",   32'h471C4000, 16'h7FFF, 1, 0, 1,  1);
        convert("pinf",     32'h7F800000, 16'h7FFF, 1, 0, 1,  0);
        convert("ninf",     32'hFF800000, 16'h8000, 1, 0, 1,  0);
        convert("nan",      32'h7FC00000, 16'h0000, 0, 1, 1,  2);
        convert("n32768p5", 32'hC7000080, 16'h8000, 1, 0, 1,  0);
        convert("big",      32'h4F000000, 16'h7FFF, 1, 0, 1,  0);
        convert("zero",     32'h00000000, 16'h0000, 0, 0, 1,  0);
        convert("subnorm",  32'h80400000, 16'h0000, 0, 0, 1,  0);
        convert("p2_5",     32'h40200000, 16'h0002, 0, 0, 2,  0);
        convert("p3_5",     32'h40600000, RND ? 16'h0004 : 16'h0003, 0, 0, 2, 0);
        convert("p0_75",    32'h3F400000, RND ? 16'h0001 : 16'h0000, 0, 0, 1, 0);
        convert("p0_5",     32'h3F000000, 16'h0000, 0, 0, 1,  0);
        convert("n1_5",     32'hBFC00000, RND ? 16'hFFFE : 16'hFFFF, 0, 0, 1, 0);
        convert("p32767_5", 32'h46FFFF00, 16'h7FFF, RND, 0, 15, 0);
        convert("n32767_5", 32'hC6FFFF00, RND ? 16'h8000 : 16'h8001, 0, 0, 15, 0);

        // Reset in the middle of ALIGN discards the conversion at once.
        wait_idle("mid_rst");
        in_valid = 1'b1;
        float_in = 32'h46FFFE00;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("mid_rst_busy", in_ready, 0);
        reset = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        convert("after_rst", 32'h3F800000, 16'h0001, 0, 0, 1, 0);
        convert("p32767",    32'h46FFFE00, 16'h7FFF, 0, 0, 15, 0);

        // Random traffic with random backpressure; the monitor checks every cycle.
        for (int i = 0; i < 300; i++) begin
            f        = rand_float();
            in_valid = 1'b1;
            float_in = f;
            n        = 0;
            do begin
                accepted = in_ready;
                @(posedge clk); #1;
                out_ready = 1'($urandom_range(0, 1));
                n++;
            end while (!accepted && n < 200);
            if (!accepted) check("rand_accept_timeout", 0, 1);
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
                out_ready = 1'($urandom_range(0, 1));
            end
        end
        out_ready = 1'b1;
        wait_idle("drain");
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
